// File: rtl/rsa_job_sequencer.sv
// rsa_job_sequencer: accepts one RSA job, sequences the control core's reset/finish
// handshakes with a per-phase watchdog, and returns the result on a response port.
module rsa_job_sequencer #(
    parameter int WIDTH          = 128,
    parameter int RESET_PULSE    = 1,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int TO_W           = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WIDTH-1:0]     req_p,
    input  logic [WIDTH-1:0]     req_q,
    input  logic                 req_mode,
    input  logic [2*WIDTH-1:0]   req_msg,
    output logic [WIDTH-1:0]     ctl_p,
    output logic [WIDTH-1:0]     ctl_q,
    output logic                 ctl_reset_inverter,
    output logic                 ctl_reset_mod_exp,
    output logic                 ctl_encrypt_decrypt,
    output logic [2*WIDTH-1:0]   ctl_msg_in,
    input  logic                 ctl_inverter_finish,
    input  logic [2*WIDTH-1:0]   ctl_msg_out,
    input  logic                 ctl_mod_exp_finish,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*WIDTH-1:0]   rsp_msg,
    output logic                 rsp_timeout,
    output logic                 busy
);
    typedef enum logic [2:0] {IDLE, INV_RST, INV_WAIT, EXP_RST, EXP_WAIT, RESP} state_t;
    localparam logic [3:0]      RP_LAST = 4'(RESET_PULSE - 1);
    localparam logic [TO_W-1:0] TO_LIM  = TO_W'(TIMEOUT_CYCLES);
    state_t             state_q, state_d;
    logic [3:0]         pulse_q, pulse_d;
    logic [TO_W-1:0]    wd_q, wd_d;
    logic [WIDTH-1:0]   p_q, q_q;
    logic               mode_q;
    logic [2*WIDTH-1:0] msg_q, rsp_msg_q, rsp_msg_d;
    logic               rsp_to_q, rsp_to_d;
    logic               inv_rst_q, exp_rst_q, req_ready_q, rsp_valid_q, busy_q;
    logic               finish;
    assign finish = (state_q == INV_WAIT) ? ctl_inverter_finish : ctl_mod_exp_finish;
    always_comb begin
        state_d   = state_q;
        pulse_d   = 4'd0;
        wd_d      = '0;
        rsp_msg_d = rsp_msg_q;
        rsp_to_d  = rsp_to_q;
        unique case (state_q)
            IDLE: state_d = req_valid ? INV_RST : IDLE;
            INV_RST, EXP_RST: begin
                pulse_d = (pulse_q == RP_LAST) ? 4'd0 : pulse_q + 4'd1;
                if (pulse_q == RP_LAST)
                    state_d = (state_q == INV_RST) ? INV_WAIT : EXP_WAIT;
            end
            INV_WAIT, EXP_WAIT: begin
                wd_d = wd_q + 1'b1;
                // first WAIT cycle ignores finish: it may still be the previous job's flag
                if (wd_q != '0 && finish) begin
                    state_d = (state_q == INV_WAIT) ? EXP_RST : RESP;
                    if (state_q == EXP_WAIT) begin
                        rsp_msg_d = ctl_msg_out;
                        rsp_to_d  = 1'b0;
                    end
                end else if (wd_d == TO_LIM) begin
                    state_d   = RESP;
                    rsp_msg_d = '0;
                    rsp_to_d  = 1'b1;
                end
            end
            RESP:    state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pulse_q     <= 4'd0;
            wd_q        <= '0;
            p_q         <= '0;
            q_q         <= '0;
            mode_q      <= 1'b0;
            msg_q       <= '0;
            rsp_msg_q   <= '0;
            rsp_to_q    <= 1'b0;
            inv_rst_q   <= 1'b0;
            exp_rst_q   <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pulse_q     <= pulse_d;
            wd_q        <= wd_d;
            rsp_msg_q   <= rsp_msg_d;
            rsp_to_q    <= rsp_to_d;
            inv_rst_q   <= state_d == INV_RST;
            exp_rst_q   <= state_d == EXP_RST;
            req_ready_q <= state_d == IDLE;
            rsp_valid_q <= state_d == RESP;
            busy_q      <= state_d != IDLE;
            if (state_q == IDLE && req_valid) begin
                p_q    <= req_p;
                q_q    <= req_q;
                mode_q <= req_mode;
                msg_q  <= req_msg;
            end
        end
    end
    assign req_ready           = req_ready_q;
    assign ctl_p               = p_q;
    assign ctl_q               = q_q;
    assign ctl_encrypt_decrypt = mode_q;
    assign ctl_msg_in          = msg_q;
    assign ctl_reset_inverter  = inv_rst_q;
    assign ctl_reset_mod_exp   = exp_rst_q;
    assign rsp_valid           = rsp_valid_q;
    assign rsp_msg             = rsp_msg_q;
    assign rsp_timeout         = rsp_to_q;
    assign busy                = busy_q;
endmodule

// File: tb/tb_rsa_job_sequencer.sv
// tb_rsa_job_sequencer: random and directed jobs against a stub control core,
// with expected latency and results computed from the phase rules.
module tb_rsa_job_sequencer;
    localparam int W  = 128;
    localparam int RP = 4;
    localparam int T  = 64;
    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           req_valid = 1'b0, req_ready;
    logic [W-1:0]   req_p = '0, req_q = '0;
    logic           req_mode = 1'b0;
    logic [2*W-1:0] req_msg = '0;
    logic [W-1:0]   ctl_p, ctl_q;
    logic           ctl_reset_inverter, ctl_reset_mod_exp, ctl_encrypt_decrypt;
    logic [2*W-1:0] ctl_msg_in, ctl_msg_out = '0;
    logic           ctl_inverter_finish = 1'b0, ctl_mod_exp_finish = 1'b0;
    logic           rsp_valid, rsp_ready = 1'b0, rsp_timeout, busy;
    logic [2*W-1:0] rsp_msg;
    rsa_job_sequencer #(.WIDTH(W), .RESET_PULSE(RP), .TIMEOUT_CYCLES(T), .TO_W(32)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_p(req_p), .req_q(req_q), .req_mode(req_mode), .req_msg(req_msg),
        .ctl_p(ctl_p), .ctl_q(ctl_q), .ctl_reset_inverter(ctl_reset_inverter),
        .ctl_reset_mod_exp(ctl_reset_mod_exp), .ctl_encrypt_decrypt(ctl_encrypt_decrypt),
        .ctl_msg_in(ctl_msg_in), .ctl_inverter_finish(ctl_inverter_finish),
        .ctl_msg_out(ctl_msg_out), .ctl_mod_exp_finish(ctl_mod_exp_finish),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_msg(rsp_msg),
        .rsp_timeout(rsp_timeout), .busy(busy)
    );
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int checks = 0, errors = 0;
    task automatic chk(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    // stub control: finish rises f cycles after its reset falls; optional stale flag
    int f1 = 1000, f2 = 1000;
    bit stale = 1'b0;
    int inv_idx = -2, exp_idx = -2;
    initial forever begin
        @(negedge clk);
        if (ctl_reset_inverter) inv_idx = -1;
        else if (inv_idx >= -1 && inv_idx < 100000) inv_idx++;
        if (ctl_reset_mod_exp) exp_idx = -1;
        else if (exp_idx >= -1 && exp_idx < 100000) exp_idx++;
        ctl_inverter_finish = ctl_reset_inverter ? stale :
                              ((inv_idx == 0 && stale) || (inv_idx >= 0 && inv_idx >= f1));
        ctl_mod_exp_finish  = ctl_reset_mod_exp ? stale :
                              ((exp_idx == 0 && stale) || (exp_idx >= 0 && exp_idx >= f2));
        ctl_msg_out = ctl_msg_in ^ 256'hA5;
    end
    int inv_start = -1, exp_start = -1, inv_w = -1, exp_w = -1;
    int inv_run = 0, exp_run = 0, overlap = 0;
    always @(negedge clk) begin
        if (ctl_reset_inverter && ctl_reset_mod_exp) overlap++;
        if (ctl_reset_inverter) begin
            if (inv_run == 0) inv_start = cyc;
            inv_run++;
        end else if (inv_run != 0) begin
            inv_w = inv_run;
            inv_run = 0;
        end
        if (ctl_reset_mod_exp) begin
            if (exp_run == 0) exp_start = cyc;
            exp_run++;
        end else if (exp_run != 0) begin
            exp_w = exp_run;
            exp_run = 0;
        end
    end
    task automatic accept(input logic [2*W-1:0] m, input logic [W-1:0] p, input logic [W-1:0] q,
                          input logic md, output int k);
        int n = 0;
        while (!req_ready && n < 1000) begin @(negedge clk); n++; end
        chk("req_ready_wait", 256'(req_ready), 256'd1);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_p = p; req_q = q; req_mode = md; req_msg = m;
        k = cyc;
        @(negedge clk);
        req_valid = 1'b0;
    endtask
    task automatic run_job(input logic [2*W-1:0] m, input logic [W-1:0] p, input logic [W-1:0] q,
                           input logic md, input int a, input int b, input bit st, input int bp);
        int k, n, q1, q2, w1, w2, lat;
        bit to1, to2;
        logic [2*W-1:0] em;
        f1 = a; f2 = b; stale = st;
        inv_start = -1; exp_start = -1; inv_w = -1; exp_w = -1;
        accept(m, p, q, md, k);
        chk("ctl_msg_in", ctl_msg_in, m);
        chk("ctl_p", 256'(ctl_p), 256'(p));
        chk("ctl_q", 256'(ctl_q), 256'(q));
        chk("ctl_mode", 256'(ctl_encrypt_decrypt), 256'(md));
        q1 = a < 1 ? 1 : a;
        q2 = b < 1 ? 1 : b;
        to1 = q1 >= T;
        to2 = q2 >= T;
        w1 = to1 ? T : q1 + 1;
        w2 = to2 ? T : q2 + 1;
        lat = to1 ? RP + T + 1 : 2 * RP + w1 + w2 + 1;
        em = (to1 || to2) ? '0 : m ^ 256'hA5;
        n = 0;
        while (!rsp_valid && n < 2000) begin @(negedge clk); n++; end
        chk("rsp_latency", 256'(cyc - k), 256'(lat));
        chk("rsp_msg", rsp_msg, em);
        chk("rsp_timeout", 256'(rsp_timeout), 256'(to1 || to2));
        chk("inv_start", 256'(inv_start), 256'(k + 1));
        chk("inv_width", 256'(inv_w), 256'(RP));
        if (!to1) begin
            chk("exp_start", 256'(exp_start), 256'(k + RP + w1 + 1));
            chk("exp_width", 256'(exp_w), 256'(RP));
        end
        for (int i = 0; i < bp; i++) begin
            req_valid = 1'b1;
            req_msg = 256'h9c000000;
            @(negedge clk);
            chk("bp_rsp_valid", 256'(rsp_valid), 256'd1);
            chk("bp_rsp_msg", rsp_msg, em);
            chk("bp_req_ready", 256'(req_ready), 256'd0);
        end
        req_valid = 1'b0;
        chk("bp_msg_in_hold", ctl_msg_in, m);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'($urandom % 2);
        chk("post_rsp_valid", 256'(rsp_valid), 256'd0);
        chk("post_busy", 256'(busy), 256'd0);
        chk("post_req_ready", 256'(req_ready), 256'd1);
    endtask
    function automatic int pick_f();
        int s = $urandom % 8;
        return s < 5 ? int'($urandom % 12) : s == 5 ? 60 + int'($urandom % 6) : s == 6 ? 1000 : int'($urandom % 3);
    endfunction
    initial begin
        int k, n;
        logic [2*W-1:0] rm;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 256'(req_ready), 256'd1);
        chk("rst_busy", 256'(busy), 256'd0);
        chk("rst_rsp_valid", 256'(rsp_valid), 256'd0);
        chk("rst_rsp_msg", rsp_msg, '0);
        chk("rst_rsp_timeout", 256'(rsp_timeout), 256'd0);
        chk("rst_ctl", {ctl_p, ctl_q}, '0);
        chk("rst_ctl_msg_in", ctl_msg_in, '0);
        chk("rst_ctl_resets", 256'({ctl_reset_inverter, ctl_reset_mod_exp, ctl_encrypt_decrypt}), 256'd0);
        reset = 1'b0;
        @(negedge clk);
        run_job(256'he7e149, 128'd113680897410347, 128'd7999808077935876437321, 1'b0, 20, 20, 1'b0, 0);
        run_job(256'h1234, 128'd7, 128'd11, 1'b1, 10, 3, 1'b1, 0);
        run_job(256'h55aa, 128'd3, 128'd5, 1'b0, 0, 0, 1'b0, 1);
        run_job(256'h77, 128'd3, 128'd5, 1'b1, 2, 1000, 1'b0, 2);
        run_job(256'h78, 128'd3, 128'd5, 1'b0, 1000, 2, 1'b0, 0);
        run_job(256'h79, 128'd3, 128'd5, 1'b0, 5, 63, 1'b0, 0);
        run_job(256'h7a, 128'd3, 128'd5, 1'b0, 63, 64, 1'b1, 0);
        run_job(256'h2b4d0e3f77000000000000, 128'd8475698667747010771, 128'd11297384090418420749,
                1'b0, 4, 6, 1'b0, 15);
        f1 = 2; f2 = 2; stale = 1'b0;
        accept(256'hbeef, 128'd13, 128'd17, 1'b1, k);
        n = 0;
        while (!ctl_reset_mod_exp && n < 200) begin @(negedge clk); n++; end
        chk("mid_reach_exp_rst", 256'(ctl_reset_mod_exp), 256'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_exp_rst", 256'(ctl_reset_mod_exp), 256'd0);
        chk("mid_busy", 256'(busy), 256'd0);
        chk("mid_req_ready", 256'(req_ready), 256'd1);
        chk("mid_rsp_valid", 256'(rsp_valid), 256'd0);
        run_job(256'hcafe, 128'd13, 128'd17, 1'b1, 3, 3, 1'b0, 0);
        for (int j = 0; j < 25; j++) begin
            rm = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run_job(rm, {4{$urandom}}, {4{$urandom}}, 1'($urandom % 2), pick_f(), pick_f(),
                    1'($urandom % 2), int'($urandom % 16));
        end
        chk("reset_overlap", 256'(overlap), 256'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rsa_job_sequencer.md
Name: rsa_job_sequencer

Overview:
- Upstream/downstream wrapper for the RSA `control` core.
- Accepts one job through a valid/ready request port: p, q, mode and message.
- Drives control's inverter-reset and mod-exp-reset pulses, waits for each finish flag, then returns msg_out on a valid/ready response port.
- A per-phase watchdog aborts a hung job, so system software never has to hand-sequence control the way a bench does.

Parameters:
WIDTH, 128, prime width; message width is 2*WIDTH
RESET_PULSE, 1, cycles each control reset pulse is held high (1..15)
TIMEOUT_CYCLES, 1048576, max cycles spent in one WAIT phase before abort (>=4)
TO_W, 32, watchdog counter width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
req_valid  in  1  job request valid
req_ready  out  1  sequencer idle, can accept
req_p  in  WIDTH  prime p
req_q  in  WIDTH  prime q
req_mode  in  1  encrypt_decrypt value for the job
req_msg  in  2*WIDTH  input message
ctl_p  out  WIDTH  to control p
ctl_q  out  WIDTH  to control q
ctl_reset_inverter  out  1  to control inverter reset
ctl_reset_mod_exp  out  1  to control mod-exp reset
ctl_encrypt_decrypt  out  1  to control
ctl_msg_in  out  2*WIDTH  to control
ctl_inverter_finish  in  1  from control
ctl_msg_out  in  2*WIDTH  from control
ctl_mod_exp_finish  in  1  from control
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_msg  out  2*WIDTH  result message (0 on timeout)
rsp_timeout  out  1  job aborted by watchdog
busy  out  1  high in any state except IDLE

Behaviour:
- All outputs are registered.
- Reset values:
  - state IDLE; req_ready=1.
  - All ctl_* outputs = 0.
  - rsp_valid=0, rsp_msg=0, rsp_timeout=0, busy=0.
  - Pulse and watchdog counters = 0.
- States: IDLE, INV_RST, INV_WAIT, EXP_RST, EXP_WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready at edge k: latch req_p/q/mode/msg into ctl_p/q/encrypt_decrypt/msg_in; go to INV_RST.
  - ctl_p/q/encrypt_decrypt/msg_in then hold constant until the next accept.
- INV_RST:
  - ctl_reset_inverter=1 for exactly RESET_PULSE cycles (cycles k+1..k+RESET_PULSE), then drops to 0.
  - Next state INV_WAIT; watchdog cleared.
- INV_WAIT:
  - Watchdog increments every cycle.
  - ctl_inverter_finish is ignored in the first WAIT cycle (guard against a stale flag from the previous job) and sampled from the second cycle on.
  - Finish seen -> EXP_RST.
  - Watchdog reaches TIMEOUT_CYCLES -> RESP with rsp_timeout=1, rsp_msg=0.
- EXP_RST: ctl_reset_mod_exp=1 for RESET_PULSE cycles, then EXP_WAIT; watchdog cleared.
- EXP_WAIT:
  - Same guard-cycle and watchdog rules as INV_WAIT.
  - Qualified ctl_mod_exp_finish -> capture ctl_msg_out into rsp_msg, set rsp_timeout=0, go to RESP.
- RESP:
  - rsp_valid=1; rsp_msg and rsp_timeout held stable.
  - On rsp_valid&&rsp_ready -> IDLE (rsp_valid=0 next cycle).
  - req_ready stays 0 until back in IDLE, so there is no back-to-back accept in the RESP cycle.
- Simultaneous qualified finish and watchdog expiry in the same cycle: finish wins, and the result is a normal completion.
- ctl_reset_inverter and ctl_reset_mod_exp are never high together, and never high outside the RST states.
- Reset mid-job:
  - Next cycle state=IDLE and all outputs at their reset values, which drops any reset pulse in progress.
  - The pending result is discarded.
- rsp_ready held high with no job pending has no effect.
- req_valid asserted while busy is ignored (req_ready=0).
- Minimum job latency, accept to rsp_valid: 2*RESET_PULSE + 5 cycles when both finishes qualify on their first sample.

Test Plan:
- Basic job with a stub control (finish flags rise 20 cycles after each reset falls; msg_out = msg_in ^ 0xA5):
  - Stimulus: p=113680897410347, q=7999808077935876437321, mode=0, msg=0xe7e149.
  - Required: one-cycle reset_inverter at k+1; reset_mod_exp after the inverter finish; rsp_msg=0xe7e1ec; rsp_timeout=0; busy low after the rsp handshake.
- Stale finish:
  - Stimulus: stub holds ctl_inverter_finish=1 through accept and the reset pulse, drops it for 1 cycle, reasserts it 10 cycles later.
  - Required: sequencer stays in INV_WAIT until the reassertion; no early reset_mod_exp.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=64, stub never raises mod_exp_finish.
  - Required: rsp_valid exactly 64 WAIT cycles after EXP_RST ends; rsp_timeout=1, rsp_msg=0.
- Backpressure and ignored request:
  - Stimulus: hold rsp_ready=0 for 15 cycles; during that time assert a second req_valid with msg=0x9c000000.
  - Required: rsp_msg stable; req_ready=0; second job accepted only after the rsp handshake and IDLE.
- Reset mid-job:
  - Stimulus: assert reset for 1 cycle during EXP_RST with RESET_PULSE=4.
  - Required: next cycle ctl_reset_mod_exp=0, busy=0, req_ready=1; a new job then completes normally.
- Round trip with real control, WIDTH=128:
  - Stimulus: two sequencers in series, modes 0 then 1; p=8475698667747010771, q=11297384090418420749, msg=0x2b4d0e3f77000000000000.
  - Required: second rsp_msg equals the original msg.
